// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port main-memory arbiter.
package mem_arb_pkg;

  localparam int unsigned DEF_ADDR_W  = 32;
  localparam int unsigned DEF_WDATA_W = 32;
  localparam int unsigned DEF_BLOCK_W = 512;

  // Port identifiers; also the encoding of the arbiter's owner/last-served bits.
  localparam logic PORT_CACHE = 1'b0;
  localparam logic PORT_WALK  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  // One-hot grant vector for a port ID (bit N = port N).
  function automatic logic [1:0] port_onehot(input logic port);
    return {port, ~port};
  endfunction

endpackage

// File: rtl/arb_req_slot.sv
// Per-port pending-request slot: captures a read/write pulse, holds it until
// the arbiter completes it, and flags protocol violations (sticky).
module arb_req_slot
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned WDATA_W = DEF_WDATA_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               read_req,
  input  logic               write_req,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [WDATA_W-1:0] wdata,
  input  logic               clear,
  output logic               valid,
  output logic               is_write,
  output logic [ADDR_W-1:0]  slot_addr,
  output logic [WDATA_W-1:0] slot_wdata,
  output logic               err
);

  logic req;
  logic can_load;

  assign req      = read_req | write_req;
  // A completing slot is free on the same edge, so a new pulse may reload it.
  assign can_load = ~valid | clear;

  // Slot contents: capture beats clear; a pulse into a busy slot is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid      <= 1'b0;
      is_write   <= 1'b0;
      slot_addr  <= '0;
      slot_wdata <= '0;
    end else if (req && can_load) begin
      valid      <= 1'b1;
      is_write   <= ~read_req;
      slot_addr  <= addr;
      slot_wdata <= wdata;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

  // Sticky protocol-error flag: dropped pulse or simultaneous read+write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if ((req && !can_load) || (read_req && write_req)) begin
      err <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port main-memory arbiter: cache controller (port 0) and page-table
// walker (port 1) share one memory interface, granted round-robin, one
// transaction at a time.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned WDATA_W = DEF_WDATA_W,
  parameter int unsigned BLOCK_W = DEF_BLOCK_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  p0_addr,
  input  logic [WDATA_W-1:0] p0_wdata,
  input  logic               p0_read_req,
  input  logic               p0_write_req,
  output logic [BLOCK_W-1:0] p0_rdata,
  output logic               p0_ready,
  input  logic [ADDR_W-1:0]  p1_addr,
  input  logic [WDATA_W-1:0] p1_wdata,
  input  logic               p1_read_req,
  input  logic               p1_write_req,
  output logic [BLOCK_W-1:0] p1_rdata,
  output logic               p1_ready,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [WDATA_W-1:0] mem_wdata,
  output logic               mem_read_req,
  output logic               mem_write_req,
  input  logic [BLOCK_W-1:0] mem_rdata,
  input  logic               mem_ready,
  output logic [1:0]         grant,
  output logic               proto_err
);

  logic               v0, w0, e0;
  logic               v1, w1, e1;
  logic [ADDR_W-1:0]  a0, a1;
  logic [WDATA_W-1:0] d0, d1;

  state_t             state;
  logic               owner;
  logic               last_served;
  logic               pick;
  logic               done;
  logic               clr0, clr1;
  logic               sel_write;
  logic [ADDR_W-1:0]  sel_addr;
  logic [WDATA_W-1:0] sel_wdata;

  assign done      = (state == S_WAIT) && mem_ready;
  assign clr0      = done && (owner == PORT_CACHE);
  assign clr1      = done && (owner == PORT_WALK);
  assign proto_err = e0 | e1;

  arb_req_slot #(.ADDR_W(ADDR_W), .WDATA_W(WDATA_W)) u_slot0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .read_req   (p0_read_req),
    .write_req  (p0_write_req),
    .addr       (p0_addr),
    .wdata      (p0_wdata),
    .clear      (clr0),
    .valid      (v0),
    .is_write   (w0),
    .slot_addr  (a0),
    .slot_wdata (d0),
    .err        (e0)
  );

  arb_req_slot #(.ADDR_W(ADDR_W), .WDATA_W(WDATA_W)) u_slot1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .read_req   (p1_read_req),
    .write_req  (p1_write_req),
    .addr       (p1_addr),
    .wdata      (p1_wdata),
    .clear      (clr1),
    .valid      (v1),
    .is_write   (w1),
    .slot_addr  (a1),
    .slot_wdata (d1),
    .err        (e1)
  );

  // Round-robin winner: on a tie the port not served last wins.
  always_comb begin
    if (v0 && v1) begin
      pick = (last_served == PORT_CACHE) ? PORT_WALK : PORT_CACHE;
    end else begin
      pick = v1 ? PORT_WALK : PORT_CACHE;
    end
  end

  // Arbitration FSM with grant register and last-served pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      owner       <= PORT_CACHE;
      last_served <= PORT_CACHE;
      grant       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (v0 || v1) begin
            owner <= pick;
            grant <= port_onehot(pick);
            state <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (mem_ready) begin
            last_served <= owner;
            grant       <= '0;
            state       <= S_IDLE;
          end
        end
        default: begin
          grant <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Memory-side mux: owner's slot drives the bus only while granted.
  always_comb begin
    sel_write     = owner ? w1 : w0;
    sel_addr      = owner ? a1 : a0;
    sel_wdata     = owner ? d1 : d0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_read_req  = 1'b0;
    mem_write_req = 1'b0;
    if (state != S_IDLE) begin
      mem_addr  = sel_addr;
      mem_wdata = sel_wdata;
    end
    if (state == S_ISSUE) begin
      mem_read_req  = ~sel_write;
      mem_write_req = sel_write;
    end
  end

  // Completion pulses; read blocks are latched only for read completions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_ready <= 1'b0;
      p1_ready <= 1'b0;
      p0_rdata <= '0;
      p1_rdata <= '0;
    end else begin
      p0_ready <= clr0;
      p1_ready <= clr1;
      if (clr0 && !w0) p0_rdata <= mem_rdata;
      if (clr1 && !w1) p1_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter with a transaction-level
// reference model of the arbitration rules.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 512;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_read_req, p0_write_req, p1_read_req, p1_write_req;
  logic [BW-1:0] p0_rdata, p1_rdata;
  logic          p0_ready, p1_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_read_req, mem_write_req;
  logic [BW-1:0] mem_rdata;
  logic          mem_ready;
  logic [1:0]    grant;
  logic          proto_err;

  mem_arbiter #(.ADDR_W(AW), .WDATA_W(DW), .BLOCK_W(BW)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_read_req(p0_read_req),
    .p0_write_req(p0_write_req), .p0_rdata(p0_rdata), .p0_ready(p0_ready),
    .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_read_req(p1_read_req),
    .p1_write_req(p1_write_req), .p1_rdata(p1_rdata), .p1_ready(p1_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read_req(mem_read_req),
    .mem_write_req(mem_write_req), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .grant(grant), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_t;

  typedef struct {
    int port;
    bit wr;
  } resp_t;

  // Reference model state: per-port pending request, the transaction in
  // flight (owner and the edge it was granted on), fairness pointer.
  int unsigned   n_edge;
  bit            pv [2];
  bit            pw [2];
  logic [31:0]   pa [2];
  logic [31:0]   pd [2];
  logic [BW-1:0] exp_rdata [2];
  int            m_owner;
  int unsigned   m_gedge;
  int            last;
  bit            m_err;
  mem_t          exp_mem [$];
  resp_t         exp_resp [$];

  int unsigned   n_cmp, n_fail;
  int unsigned   ready_cnt [2];
  bit            alt_mode;
  int            alt_prev;

  function automatic logic [1:0] oh(int p);
    return (p == 1) ? 2'b10 : 2'b01;
  endfunction

  function automatic void chk(string nm, logic [BW-1:0] act, logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  function automatic void fail_evt(string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got event expected none (t=%0t)", nm, $time);
  endfunction

  function automatic logic [BW-1:0] rand_blk();
    logic [BW-1:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic void model_reset();
    for (int p = 0; p < 2; p++) begin
      pv[p] = 0; pw[p] = 0; pa[p] = '0; pd[p] = '0; exp_rdata[p] = '0;
    end
    m_owner = -1;
    m_gedge = 0;
    last    = 0;
    m_err   = 0;
    exp_mem.delete();
    exp_resp.delete();
  endfunction

  // One clock edge of the reference model, using the inputs the bench drove.
  function automatic void model_step();
    bit          rd [2], wr [2];
    logic [31:0] ad [2], wd [2];
    bit          gnt, comp;
    int          win;
    mem_t        m;
    resp_t       r;
    rd[0] = p0_read_req; wr[0] = p0_write_req; ad[0] = p0_addr; wd[0] = p0_wdata;
    rd[1] = p1_read_req; wr[1] = p1_write_req; ad[1] = p1_addr; wd[1] = p1_wdata;
    n_edge++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    gnt  = (m_owner < 0) && (pv[0] || pv[1]);
    win  = (pv[0] && pv[1]) ? (1 - last) : (pv[1] ? 1 : 0);
    comp = (m_owner >= 0) && (n_edge >= m_gedge + 2) && mem_ready;
    if (comp) begin
      r.port = m_owner; r.wr = pw[m_owner];
      exp_resp.push_back(r);
      if (!pw[m_owner]) exp_rdata[m_owner] = mem_rdata;
      last = m_owner;
      pv[m_owner] = 0;
      m_owner = -1;
    end
    if (gnt) begin
      m_owner = win;
      m_gedge = n_edge;
      m.port = win; m.wr = pw[win]; m.addr = pa[win]; m.wdata = pd[win];
      exp_mem.push_back(m);
    end
    for (int p = 0; p < 2; p++) begin
      if (rd[p] || wr[p]) begin
        if (pv[p]) begin
          m_err = 1;
        end else begin
          pv[p] = 1; pw[p] = !rd[p]; pa[p] = ad[p]; pd[p] = wd[p];
          if (rd[p] && wr[p]) m_err = 1;
        end
      end
    end
  endfunction

  always @(posedge clk) model_step();

  // Monitor: compares outputs each cycle and pops the scoreboard queues
  // whenever the DUT presents a memory request or a completion.
  always @(negedge clk) begin : mon
    logic [1:0] eg;
    mem_t       e;
    resp_t      r;
    eg = (m_owner < 0) ? 2'b00 : oh(m_owner);
    chk("grant", grant, eg);
    chk("mem_addr", mem_addr, (m_owner < 0) ? '0 : pa[m_owner]);
    chk("mem_wdata", mem_wdata, (m_owner < 0) ? '0 : pd[m_owner]);
    chk("proto_err", proto_err, m_err);
    chk("mem_req_cycle", mem_read_req | mem_write_req,
        (m_owner >= 0) && (n_edge == m_gedge));
    chk("p0_rdata", p0_rdata, exp_rdata[0]);
    chk("p1_rdata", p1_rdata, exp_rdata[1]);
    if (mem_read_req || mem_write_req) begin
      if (exp_mem.size() == 0) begin
        fail_evt("mem_req_unexpected");
      end else begin
        e = exp_mem.pop_front();
        chk("mem_port", grant, oh(e.port));
        chk("mem_write_req", mem_write_req, e.wr);
        chk("mem_read_req", mem_read_req, !e.wr);
        chk("mem_req_addr", mem_addr, e.addr);
        if (e.wr) chk("mem_req_wdata", mem_wdata, e.wdata);
        if (alt_mode) begin
          if (alt_prev >= 0) chk("alternation", e.port, 1 - alt_prev);
          alt_prev = e.port;
        end
      end
    end
    if (p0_ready || p1_ready) begin
      if (p0_ready && p1_ready) fail_evt("both_ready");
      if (exp_resp.size() == 0) begin
        fail_evt("ready_unexpected");
      end else begin
        r = exp_resp.pop_front();
        chk("ready_port", {p1_ready, p0_ready}, oh(r.port));
        if (p0_ready) ready_cnt[0]++;
        if (p1_ready) ready_cnt[1]++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
    p0_read_req = 0; p0_write_req = 0; p1_read_req = 0; p1_write_req = 0;
    mem_ready = 0;
    mem_rdata = rand_blk();
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_reset();
    step();
    step();
    rst_n = 1;
    step();
  endtask

  int unsigned c0, c1, iss0, iss1;

  initial begin
    n_cmp = 0; n_fail = 0; ready_cnt[0] = 0; ready_cnt[1] = 0;
    alt_mode = 0; alt_prev = -1; n_edge = 0;
    rst_n = 0;
    p0_addr = '0; p0_wdata = '0; p1_addr = '0; p1_wdata = '0;
    p0_read_req = 0; p0_write_req = 0; p1_read_req = 0; p1_write_req = 0;
    mem_ready = 0; mem_rdata = '0;
    model_reset();

    // Reset state
    step(); step();
    chk("rst_p0_ready", p0_ready, 1'b0);
    chk("rst_p1_ready", p1_ready, 1'b0);
    chk("rst_mem_req", {mem_read_req, mem_write_req}, 2'b00);
    rst_n = 1;
    step();

    // Single cache read, memory answers two cycles after ISSUE
    p0_read_req = 1; p0_addr = 32'h0000_1040; step();
    step(); step(); step();
    mem_ready = 1; step();
    repeat (3) step();

    // Simultaneous requests right after reset: walker wins the first tie
    do_reset();
    p0_read_req = 1; p0_addr = 32'h0000_2000;
    p1_write_req = 1; p1_addr = 32'h8000_0000; p1_wdata = 32'hDEAD_BEEF;
    step();
    repeat (12) begin mem_ready = 1; step(); end

    // Pulse into a pending walker slot is dropped and flagged
    do_reset();
    p1_read_req = 1; p1_addr = 32'h0000_3000; step();
    p1_read_req = 1; p1_addr = 32'h0000_4000; step();
    repeat (8) begin mem_ready = 1; step(); end

    // New cache pulse on its own completion edge is accepted
    do_reset();
    p0_read_req = 1; p0_addr = 32'h0000_5000; step();
    step(); step();
    mem_ready = 1; p0_read_req = 1; p0_addr = 32'h0000_6000; step();
    repeat (8) begin mem_ready = 1; step(); end

    // Reset while waiting on memory; late mem_ready must be ignored
    do_reset();
    p0_read_req = 1; p0_addr = 32'h0000_7000; step();
    step(); step(); step();
    rst_n = 0; model_reset(); step();
    rst_n = 1;
    repeat (4) begin mem_ready = 1; step(); end
    chk("post_rst_p0_rdata", p0_rdata, '0);

    // Ten requests per port, continuously: strict alternation
    do_reset();
    c0 = ready_cnt[0]; c1 = ready_cnt[1]; iss0 = 0; iss1 = 0;
    alt_mode = 1; alt_prev = -1;
    for (int i = 0; i < 120; i++) begin
      if (!pv[0] && iss0 < 10) begin
        p0_read_req = 1; p0_addr = $urandom(); iss0++;
      end
      if (!pv[1] && iss1 < 10) begin
        p1_write_req = 1; p1_addr = $urandom(); p1_wdata = $urandom(); iss1++;
      end
      mem_ready = 1;
      step();
    end
    alt_mode = 0;
    chk("p0_served_10", ready_cnt[0] - c0, 10);
    chk("p1_served_10", ready_cnt[1] - c1, 10);

    // Random traffic with random memory latency and one mid-run reset
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        rst_n = 0; model_reset(); step(); rst_n = 1;
      end
      if ($urandom_range(3) == 0) begin
        p0_addr = $urandom(); p0_wdata = $urandom();
        if ($urandom_range(15) == 0) begin p0_read_req = 1; p0_write_req = 1; end
        else if ($urandom_range(1) == 0) p0_read_req = 1;
        else p0_write_req = 1;
      end
      if ($urandom_range(3) == 0) begin
        p1_addr = $urandom(); p1_wdata = $urandom();
        if ($urandom_range(15) == 0) begin p1_read_req = 1; p1_write_req = 1; end
        else if ($urandom_range(1) == 0) p1_read_req = 1;
        else p1_write_req = 1;
      end
      mem_ready = ($urandom_range(2) == 0);
      step();
    end
    repeat (20) begin mem_ready = 1; step(); end
    chk("drain_mem_queue", exp_mem.size(), 0);
    chk("drain_resp_queue", exp_resp.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
